// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the RAM block copy / fill engine.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Loadable word pointer that steps up or down by one, wrapping modulo 2^ADDR_W.
module mem_copy_addr_gen #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (load) ptr <= load_addr;
    else if (step) ptr <= down ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
  end

endmodule

// File: rtl/mem_block_copy.sv
// Bus-master engine driving the single-port RAM for block copy or block fill.
module mem_block_copy
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   remaining,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_out,
  input  logic [DATA_W-1:0] mem_d_in
);

  state_t            state;
  logic              mode_q;
  logic              down_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;

  logic              accept;
  logic              desc;
  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] src_load, dst_load;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign diff   = dst_addr - src_addr;
  assign len_m1 = len[ADDR_W-1:0] - ADDR_W'(1);

  // Destination lies inside the source window ahead of it: copy from the top
  // down so no source word is overwritten before it is read.
  assign desc     = (mode == MODE_COPY) && (diff != '0) && ({1'b0, diff} < len);
  assign src_load = src_addr + (desc ? len_m1 : '0);
  assign dst_load = dst_addr + (desc ? len_m1 : '0);

  mem_copy_addr_gen #(.ADDR_W(ADDR_W)) u_src (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (src_load),
    .step      ((state == ST_WR) && (mode_q == MODE_COPY)),
    .down      (down_q),
    .ptr       (src_ptr)
  );

  mem_copy_addr_gen #(.ADDR_W(ADDR_W)) u_dst (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_addr (dst_load),
    .step      (state == ST_WR),
    .down      (down_q),
    .ptr       (dst_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_COPY;
      down_q <= 1'b0;
      fill_q <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_q <= mode;
            down_q <= desc;
            fill_q <= fill_data;
            rem_q  <= len;
            if (len == '0)             state <= ST_DONE;
            else if (mode == MODE_FILL) state <= ST_WR;
            else                       state <= ST_RD;
          end
        end
        ST_RD:  state <= ST_LAT;
        ST_LAT: begin
          data_q <= mem_d_in;
          state  <= ST_WR;
        end
        ST_WR: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1))  state <= ST_DONE;
          else if (mode_q == MODE_FILL) state <= ST_WR;
          else                          state <= ST_RD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_RD) || (state == ST_LAT) || (state == ST_WR);
    done      = (state == ST_DONE);
    remaining = rem_q;
    mem_w_en  = (state == ST_WR);
    mem_d_out = data_q;
    mem_addr  = '0;
    case (state)
      ST_RD, ST_LAT: mem_addr = src_ptr;
      ST_WR: begin
        mem_addr = dst_ptr;
        if (mode_q == MODE_FILL) mem_d_out = fill_q;
      end
      default: mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_block_copy.sv
// Directed bench: RAM model plus write scoreboard checked by a separate monitor.
module tb_mem_block_copy;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          busy, done, mem_w_en;
  logic [AW:0]   remaining;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_out;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  mem_block_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_d_out (mem_d_out),
    .mem_d_in  (ram_dout)
  );

  // Single-port RAM: one-cycle read latency, output held on write cycles.
  always @(posedge clk) begin
    if (pl_en)         ram[pl_addr] <= pl_data;
    else if (mem_w_en) ram[mem_addr] <= mem_d_out;
    else               ram_dout <= ram[mem_addr];
  end

  // Monitor: every write cycle must match the next expected write.
  always @(negedge clk) begin
    if (mem_w_en) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", mem_addr, mem_d_out);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_d_out !== e.d) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                   mem_addr, mem_d_out, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Returns with the bench observing cycle 1 (one step after the start edge).
  task automatic do_start(input logic md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l, input logic [DW-1:0] f);
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int cyc0, input int exp_cyc);
    int c;
    c = cyc0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, c, exp_cyc);
  endtask

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_en", mem_w_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_d_out", mem_d_out, 0);
    chk("rst_remaining", remaining, 0);
    @(negedge clk); rst = 1'b0;

    // Ascending copy
    preload(13'h100, 32'hAAAA_0001);
    preload(13'h101, 32'hBBBB_0002);
    preload(13'h102, 32'hCCCC_0003);
    preload(13'h103, 32'hDDDD_0004);
    push(13'h200, 32'hAAAA_0001); push(13'h201, 32'hBBBB_0002);
    push(13'h202, 32'hCCCC_0003); push(13'h203, 32'hDDDD_0004);
    w0 = wr_cnt;
    do_start(1'b0, 13'h100, 13'h200, 14'd4, 32'h0);
    chk("asc_busy_c1", busy, 1);
    chk("asc_remaining_c1", remaining, 4);
    wait_done("asc_done_cycle", 1, 13);
    chk("asc_writes", wr_cnt - w0, 4);
    chk("asc_dst0", ram[13'h200], 32'hAAAA_0001);
    chk("asc_dst3", ram[13'h203], 32'hDDDD_0004);
    chk("asc_src1", ram[13'h101], 32'hBBBB_0002);
    chk("asc_src3", ram[13'h103], 32'hDDDD_0004);

    // Overlapping forward move, restarted from DONE
    preload(13'd10, 32'd1); preload(13'd11, 32'd2);
    preload(13'd12, 32'd3); preload(13'd13, 32'd4);
    push(13'd14, 32'd4); push(13'd13, 32'd3); push(13'd12, 32'd2); push(13'd11, 32'd1);
    do_start(1'b0, 13'd10, 13'd11, 14'd4, 32'h0);
    chk("ovl_done_cleared", done, 0);
    wait_done("ovl_done_cycle", 1, 13);
    chk("ovl_q_empty", exp_q.size(), 0);
    chk("ovl_r11", ram[13'd11], 1);
    chk("ovl_r14", ram[13'd14], 4);
    chk("ovl_r10", ram[13'd10], 1);

    // Fill wrapping past the top of memory
    push(13'd8190, 32'hDEAD_BEEF); push(13'd8191, 32'hDEAD_BEEF);
    push(13'd0, 32'hDEAD_BEEF);    push(13'd1, 32'hDEAD_BEEF);
    do_start(1'b1, 13'd0, 13'd8190, 14'd4, 32'hDEAD_BEEF);
    wait_done("fill_done_cycle", 1, 5);
    chk("fill_q_empty", exp_q.size(), 0);
    chk("fill_r0", ram[13'd0], 32'hDEAD_BEEF);

    // len = 0
    w0 = wr_cnt;
    do_start(1'b0, 13'd5, 13'd6, 14'd0, 32'h0);
    chk("len0_done_c1", done, 1);
    chk("len0_busy_c1", busy, 0);
    @(posedge clk); #1;
    chk("len0_writes", wr_cnt - w0, 0);

    // start while busy is ignored
    preload(13'h300, 32'h1234_5678);
    preload(13'h301, 32'h9ABC_DEF0);
    push(13'h400, 32'h1234_5678); push(13'h401, 32'h9ABC_DEF0);
    do_start(1'b0, 13'h300, 13'h400, 14'd2, 32'h0);
    mode = 1'b1; dst_addr = 13'h500; len = 14'd5; fill_data = 32'h5555_5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_remaining", remaining, 2);
    chk("busy_start_busy", busy, 1);
    wait_done("busy_start_done_cycle", 2, 7);
    chk("busy_start_q_empty", exp_q.size(), 0);

    // Reset during the second write of an 8-word copy
    for (int i = 0; i < 8; i++) preload(AW'(13'h700 + i), 32'hC0DE_0000 + i);
    push(13'h600, 32'hC0DE_0000); push(13'h601, 32'hC0DE_0001);
    w0 = wr_cnt;
    do_start(1'b0, 13'h700, 13'h600, 14'd8, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    chk("rstmid_in_wr", mem_w_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_w_en", mem_w_en, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_d_out", mem_d_out, 0);
    chk("rstmid_remaining", remaining, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("rstmid_writes", wr_cnt - w0, 2);
    chk("rstmid_q_empty", exp_q.size(), 0);
    chk("rstmid_w1", ram[13'h601], 32'hC0DE_0001);
    for (int i = 2; i < 8; i++) chk("rstmid_untouched", ram[AW'(13'h600 + i)], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
